// File: rtl/id_check_scheduler.sv
// Round-robin time-sharing of one serial ID checker among NREQ requesters.
// Latches and format-screens a 10-char ID, streams it to the checker and returns the verdict.
//
// state | meaning
// IDLE  | no job; arbitrate among pending requests
// SEND  | streaming chars 0..9 to the checker, one per cycle
// WAIT  | waiting for checker verdict, bounded by TIMEOUT
// RESP  | one-cycle done pulse with verdict to the granted requester
// GAP   | idle cycles so the checker clears its counter/sum
module id_check_scheduler #(
  parameter int NREQ    = 4,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*60-1:0]   req_id,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 done_legal,
  output logic                 done_err,
  output logic                 busy,
  output logic                 chk_in_valid,
  output logic [5:0]           chk_in_id,
  input  logic                 chk_out_valid,
  input  logic                 chk_out_legal
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RESP, S_GAP} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]  rr_q, idx_q, pick_idx, gidx;
  logic              pick_found, fmt_ok;
  logic [59:0]       sel_id;
  logic [53:0]       sreg_q;
  logic [3:0]        send_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [NREQ-1:0]   grant_d, done_d;
  logic              legal_d, err_d, civ_d, busy_d;
  logic [5:0]        cid_d;

  // Scan downward in offset so the lowest offset from rr_q wins.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[IDX_W'(j)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_idx == IDX_W'(i)) sel_id = req_id[i*60 +: 60];
  end

  always_comb begin
    fmt_ok = (sel_id[5:0] >= 6'd10) && (sel_id[5:0] <= 6'd35);
    for (int k = 1; k < 10; k++)
      if (sel_id[k*6 +: 6] > 6'd9) fmt_ok = 1'b0;
  end

  assign gidx = (state_q == S_IDLE) ? pick_idx : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_found) state_d = fmt_ok ? S_SEND : S_RESP;
      S_SEND:  if (send_cnt_q == 4'd0) state_d = S_WAIT;
      S_WAIT:  if (chk_out_valid || wait_cnt_q == '0) state_d = S_RESP;
      S_RESP:  state_d = S_GAP;
      S_GAP:   if (gap_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the state being entered.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    legal_d = 1'b0;
    err_d   = 1'b0;
    civ_d   = 1'b0;
    cid_d   = '0;
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_SEND || state_d == S_WAIT || state_d == S_RESP)
      grant_d = NREQ'(1) << gidx;
    if (state_d == S_SEND) begin
      civ_d = 1'b1;
      cid_d = (state_q == S_IDLE) ? sel_id[5:0] : sreg_q[5:0];
    end
    if (state_d == S_RESP) begin
      done_d = NREQ'(1) << gidx;
      if (state_q == S_WAIT && chk_out_valid) legal_d = chk_out_legal;
      else                                     err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= '0;
      done         <= '0;
      done_legal   <= 1'b0;
      done_err     <= 1'b0;
      busy         <= 1'b0;
      chk_in_valid <= 1'b0;
      chk_in_id    <= '0;
    end else begin
      grant        <= grant_d;
      done         <= done_d;
      done_legal   <= legal_d;
      done_err     <= err_d;
      busy         <= busy_d;
      chk_in_valid <= civ_d;
      chk_in_id    <= cid_d;
    end
  end

  // Char 0 goes straight out of the request slice; chars 1..9 are held in sreg_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      idx_q      <= '0;
      sreg_q     <= '0;
      send_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (pick_found) begin
          idx_q      <= pick_idx;
          sreg_q     <= sel_id[59:6];
          send_cnt_q <= 4'd9;
        end
        S_SEND: begin
          sreg_q <= {6'd0, sreg_q[53:6]};
          if (send_cnt_q == 4'd0) wait_cnt_q <= WAIT_W'(TIMEOUT - 1);
          else                    send_cnt_q <= send_cnt_q - 4'd1;
        end
        S_WAIT: if (wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
        S_RESP: begin
          rr_q      <= (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
          gap_cnt_q <= GAP_W'(GAP_CYC - 1);
        end
        S_GAP:  if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_check_scheduler.sv
// Bench for id_check_scheduler: directed and random jobs against an arbitration/timing model,
// with a behavioural checksum checker standing in for the serial ID checker.
module tb_id_check_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [239:0] req_id;
  logic [3:0]   grant, done;
  logic         done_legal, done_err, busy, chk_in_valid;
  logic [5:0]   chk_in_id;
  logic         chk_out_valid, chk_out_legal;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   suppress = 1'b0;
  int   ids[4][10];
  int   rr_m = 0;
  logic [3:0] pend = '0;
  int   cm_cnt, cm_sum;

  always #5 clk = ~clk;

  id_check_scheduler #(.NREQ(4), .GAP_CYC(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_id(req_id),
    .grant(grant), .done(done), .done_legal(done_legal), .done_err(done_err),
    .busy(busy), .chk_in_valid(chk_in_valid), .chk_in_id(chk_in_id),
    .chk_out_valid(chk_out_valid), .chk_out_legal(chk_out_legal)
  );

  function automatic int weight(input int k, input int c);
    if (k == 0) return c / 10 + (c % 10) * 9;
    if (k == 9) return c;
    return c * (9 - k);
  endfunction

  function automatic int tw_sum(input int c[10]);
    int s = 0;
    for (int k = 0; k < 10; k++) s += weight(k, c[k]);
    return s;
  endfunction

  function automatic bit fmt_ok(input int c[10]);
    bit ok = (c[0] >= 10) && (c[0] <= 35);
    for (int k = 1; k < 10; k++) if (c[k] > 9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [59:0] pack_id(input int c[10]);
    logic [59:0] p = '0;
    for (int k = 0; k < 10; k++) p[k*6 +: 6] = 6'(c[k]);
    return p;
  endfunction

  function automatic int pick(input int rr, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[(rr + i) % 4]) return (rr + i) % 4;
    return 0;
  endfunction

  // Checker stand-in: weighted running sum, verdict one cycle after the tenth char.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_cnt <= 0; cm_sum <= 0; chk_out_valid <= 1'b0; chk_out_legal <= 1'b0;
    end else begin
      chk_out_valid <= 1'b0;
      chk_out_legal <= 1'b0;
      if (chk_in_valid) begin
        if (cm_cnt == 9) begin
          cm_cnt        <= 0;
          cm_sum        <= 0;
          chk_out_valid <= !suppress;
          chk_out_legal <= !suppress && ((cm_sum + int'(chk_in_id)) % 10 == 0);
        end else begin
          cm_cnt <= cm_cnt + 1;
          cm_sum <= cm_sum + weight(cm_cnt, int'(chk_in_id));
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_id(input int i, input int c[10]);
    ids[i] = c;
    req_id[i*60 +: 60] = pack_id(c);
  endtask

  // kind: 0 legal, 1 bad checksum, 2 bad letter, 3 bad digit
  task automatic gen_load(input int i, input int kind);
    int c[10];
    int s;
    c[0] = int'($urandom_range(10, 35));
    for (int k = 1; k < 9; k++) c[k] = int'($urandom_range(0, 9));
    c[9] = 0;
    s = tw_sum(c);
    c[9] = (10 - s % 10) % 10;
    if (kind == 1) c[9] = (c[9] + 1 + int'($urandom_range(0, 8))) % 10;
    if (kind == 2) c[0] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(36, 63));
    if (kind == 3) c[int'($urandom_range(1, 9))] = int'($urandom_range(10, 63));
    load_id(i, c);
  endtask

  task automatic raise(input int i);
    req[i]  = 1'b1;
    pend[i] = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int lat, output int first_v, output int n_v,
                           output logic [59:0] sent, output bit leak, output bit ok);
    lat = 0; first_v = -1; n_v = 0; sent = '0; leak = 1'b0; ok = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (chk_in_valid) begin
        if (first_v < 0) first_v = c;
        if (n_v < 10) sent[n_v*6 +: 6] = chk_in_id;
        n_v++;
      end else if (chk_in_id != 6'd0) leak = 1'b1;
      if (|done) begin
        lat = c;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  // Serve the next pending job; after_done means counting starts at the previous done pulse.
  task automatic serve(input bit after_done);
    int who, base, exp_lat, lat, fv, nv;
    logic [59:0] sent;
    bit leak, ok, f, exp_legal, exp_err;
    who       = pick(rr_m, pend);
    f         = fmt_ok(ids[who]);
    base      = after_done ? 3 : 0;
    exp_lat   = base + (!f ? 1 : (suppress ? 27 : 12));
    exp_legal = f && !suppress && (tw_sum(ids[who]) % 10 == 0);
    exp_err   = !f || suppress;
    wait_done(exp_lat + 20, lat, fv, nv, sent, leak, ok);
    check("done_seen", 64'(ok), 64'(1));
    check("done_vec", 64'(done), 64'(4'b0001 << who));
    check("grant_at_done", 64'(grant), 64'(4'b0001 << who));
    check("latency", 64'(lat), 64'(exp_lat));
    check("done_legal", 64'(done_legal), 64'(exp_legal));
    check("done_err", 64'(done_err), 64'(exp_err));
    check("n_chars", 64'(nv), f ? 64'(10) : 64'(0));
    if (f) begin
      check("first_char_cycle", 64'(fv), 64'(base + 1));
      check("chars", 64'(sent), 64'(pack_id(ids[who])));
    end
    check("id_zero_when_invalid", 64'(leak), 64'(0));
    rr_m      = (who + 1) % 4;
    pend[who] = 1'b0;
    req[who]  = 1'b0;
  endtask

  initial begin
    int t[10];
    int kind;
    rst_n  = 1'b1;
    req    = '0;
    req_id = '0;
    for (int i = 0; i < 4; i++) gen_load(i, 0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({grant, done, done_legal, done_err, busy, chk_in_valid, chk_in_id}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_not_busy", 64'(busy), 64'(0));

    // Known legal and checksum-bad IDs
    t = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_id(0, t);
    raise(0);
    serve(1'b0);
    repeat (3) @(negedge clk);
    t = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 8};
    load_id(1, t);
    raise(1);
    serve(1'b0);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      check("gap_no_valid", 64'({chk_in_valid, grant}), 64'(0));
      check("gap_busy", 64'(busy), 64'(1));
    end
    @(negedge clk);
    check("idle_after_gap", 64'(busy), 64'(0));

    // All four at once, then re-raise 0 and 2
    for (int i = 0; i < 4; i++) begin gen_load(i, 0); raise(i); end
    serve(1'b0);
    for (int i = 0; i < 3; i++) serve(1'b1);
    gen_load(0, 0); gen_load(2, 0);
    raise(0); raise(2);
    serve(1'b1);
    serve(1'b1);
    repeat (3) @(negedge clk);

    // Format errors: bad letter, then a two-digit digit
    t = '{5, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_id(2, t);
    raise(2);
    serve(1'b0);
    repeat (3) @(negedge clk);
    t = '{20, 1, 2, 3, 4, 5, 6, 12, 8, 9};
    load_id(2, t);
    raise(2);
    serve(1'b0);
    repeat (3) @(negedge clk);

    // Checker timeout followed by a queued job
    gen_load(0, 0); gen_load(1, 0);
    raise(0); raise(1);
    suppress = 1'b1;
    serve(1'b0);
    suppress = 1'b0;
    serve(1'b1);
    repeat (3) @(negedge clk);

    // Random request mixes
    for (int r = 0; r < 20; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) if (m[i]) begin
        kind = int'($urandom_range(0, 5));
        gen_load(i, (kind < 3) ? 0 : kind - 2);
        raise(i);
      end
      suppress = ($urandom_range(0, 5) == 0);
      serve(1'b0);
      suppress = 1'b0;
      while (pend != 4'b0000) serve(1'b1);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of SEND, then full resend
    gen_load(3, 0);
    raise(3);
    repeat (5) @(negedge clk);
    check("mid_send_valid", 64'(chk_in_valid), 64'(1));
    check("mid_send_char4", 64'(chk_in_id), 64'(ids[3][4]));
    rst_n = 1'b0;
    #1;
    check("reset_mid_job", 64'({grant, done, done_legal, done_err, busy, chk_in_valid, chk_in_id}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_m  = 0;
    serve(1'b0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
